key_conditioner: RTL and testbench

- Front-end conditioner for the washer's mechanical pushbuttons: POWER, STOP, SET_M, SET_W.
- Sits between the board pins and the washer top level.
- Synchronises each raw key to CLK, debounces it on a shared 1 ms timebase, and produces a clean level plus single-cycle press, release, long-press and auto-repeat pulses.
- The controller, mode-select and auto-close logic consume these outputs in place of raw pins.

---
 rtl/key_pkg.sv | 30 +++
 rtl/key_conditioner_if.sv | 46 ++++
 rtl/key_channel.sv | 199 +++++++++++++++++++
 rtl/key_conditioner.sv | 90 +++++++++
 tb/tb_key_conditioner.sv | 324 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/key_pkg.sv
// Purpose : shared types and constants for the pushbutton conditioner.
// Latency : n/a (types, constants and a width helper only).
// Backpress: n/a.
//
// Contents:
//   key_state_t - per-channel debounce/hold state.
//   K_*         - key channel index of each washer button.
//   cnt_width() - bit width of a counter running 0..terminal-1.
package key_pkg;

   typedef enum logic [2:0] {
      IDLE         = 3'd0,
      PRESS_WAIT   = 3'd1,
      HELD         = 3'd2,
      REPEAT       = 3'd3,
      RELEASE_WAIT = 3'd4
   } key_state_t;

   localparam int K_POWER = 0;
   localparam int K_STOP  = 1;
   localparam int K_SETM  = 2;
   localparam int K_SETW  = 3;

   // A counter that stops at terminal-1 needs $clog2(terminal) bits; keep
   // at least one bit so a terminal of 1 still yields a legal vector.
   function automatic int cnt_width(input int terminal);
      return (terminal <= 1) ? 1 : $clog2(terminal);
   endfunction

endpackage

// File: rtl/key_conditioner_if.sv
// Purpose : bundle of raw key pins and conditioned key events.
// Latency : n/a (wiring only).
// Backpress: none; all event signals are single-cycle pulses, no handshake.
//
// Signals:
//   key_raw     - raw pin levels into the conditioner (asynchronous).
//   key_level   - debounced pressed level per key.
//   key_press   - 1-cycle pulse on accepted press.
//   key_release - 1-cycle pulse on accepted release.
//   key_long    - 1-cycle pulse when a key has been held the long-press time.
//   key_rep     - 1-cycle auto-repeat pulse after key_long while held.
//   key_any     - OR of key_press, aligned with it.
// Modports: master = conditioner side, slave = pin driver / consumer side.
interface key_conditioner_if #(
   parameter int N_KEYS = 4
);

   logic [N_KEYS-1:0] key_raw;
   logic [N_KEYS-1:0] key_level;
   logic [N_KEYS-1:0] key_press;
   logic [N_KEYS-1:0] key_release;
   logic [N_KEYS-1:0] key_long;
   logic [N_KEYS-1:0] key_rep;
   logic              key_any;

   modport master (
      input  key_raw,
      output key_level,
      output key_press,
      output key_release,
      output key_long,
      output key_rep,
      output key_any
   );

   modport slave (
      output key_raw,
      input  key_level,
      input  key_press,
      input  key_release,
      input  key_long,
      input  key_rep,
      input  key_any
   );

endinterface

// File: rtl/key_channel.sv
// Purpose : one key - polarity, 2-flop synchroniser, debounce FSM, long/repeat timing.
// Latency : pin to sync 2 CLK; accept after DEB_MS ticks; all outputs registered.
// Backpress: none; pulses are fire-and-forget, exactly 1 CLK wide.
//
// Ports:
//   CLK, CLR     - clock, asynchronous active-high reset.
//   i_raw        - raw pin level (asynchronous).
//   i_tick       - shared 1 ms timebase strobe, 1 CLK wide.
//   o_level      - debounced pressed level.
//   o_press      - press pulse (registered).
//   o_press_nxt  - next-cycle value of o_press, so the top can register key_any in step.
//   o_release    - release pulse.
//   o_long       - long-press pulse.
//   o_rep        - auto-repeat pulse.
module key_channel
   import key_pkg::*;
#(
   parameter int DEB_MS      = 20,
   parameter int LONG_MS     = 1000,
   parameter int REP_MS      = 200,
   parameter bit ACTIVE_HIGH = 1'b1
) (
   input  logic CLK,
   input  logic CLR,
   input  logic i_raw,
   input  logic i_tick,
   output logic o_level,
   output logic o_press,
   output logic o_press_nxt,
   output logic o_release,
   output logic o_long,
   output logic o_rep
);

   localparam int DW = cnt_width(DEB_MS);
   localparam int HW = cnt_width(LONG_MS);
   localparam int RW = cnt_width(REP_MS);

   localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_MS - 1);
   localparam logic [HW-1:0] LONG_LAST = HW'(LONG_MS - 1);
   localparam logic [RW-1:0] REP_LAST  = RW'(REP_MS - 1);

   // Polarity is normalised before synchronising, so the flops reset to
   // 0 which is always the released level.
   logic w_pol;
   logic r_sync1;
   logic r_sync2;

   assign w_pol = ACTIVE_HIGH ? i_raw : ~i_raw;

   always_ff @(posedge CLK or posedge CLR) begin
      if (CLR) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
      end else begin
         r_sync1 <= w_pol;
         r_sync2 <= r_sync1;
      end
   end

   key_state_t      r_state, w_state;
   key_state_t      r_ret,   w_ret;      // state to resume if a release turns out to be a glitch
   logic [DW-1:0]   r_deb,   w_deb;
   logic [HW-1:0]   r_hold,  w_hold;
   logic [RW-1:0]   r_rcnt,  w_rcnt;
   logic            r_level, w_level;
   logic            r_press, w_press;
   logic            r_rel,   w_rel;
   logic            r_long,  w_long;
   logic            r_rep,   w_rep;

   always_ff @(posedge CLK or posedge CLR) begin
      if (CLR) begin
         r_state <= IDLE;
         r_ret   <= HELD;
         r_deb   <= '0;
         r_hold  <= '0;
         r_rcnt  <= '0;
         r_level <= 1'b0;
         r_press <= 1'b0;
         r_rel   <= 1'b0;
         r_long  <= 1'b0;
         r_rep   <= 1'b0;
      end else begin
         r_state <= w_state;
         r_ret   <= w_ret;
         r_deb   <= w_deb;
         r_hold  <= w_hold;
         r_rcnt  <= w_rcnt;
         r_level <= w_level;
         r_press <= w_press;
         r_rel   <= w_rel;
         r_long  <= w_long;
         r_rep   <= w_rep;
      end
   end

   // A low sync level takes priority over a coincident tick in HELD and
   // REPEAT: that tick is not counted, so hold/repeat time only accrues
   // while the key is seen pressed.
   always_comb begin
      w_state = r_state;
      w_ret   = r_ret;
      w_deb   = r_deb;
      w_hold  = r_hold;
      w_rcnt  = r_rcnt;
      w_level = r_level;
      w_press = 1'b0;
      w_rel   = 1'b0;
      w_long  = 1'b0;
      w_rep   = 1'b0;

      case (r_state)
         IDLE: begin
            if (r_sync2) begin
               w_state = PRESS_WAIT;
               w_deb   = '0;
            end
         end

         PRESS_WAIT: begin
            if (!r_sync2) begin
               w_state = IDLE;
               w_deb   = '0;
            end else if (i_tick) begin
               if (r_deb == DEB_LAST) begin
                  w_state = HELD;
                  w_level = 1'b1;
                  w_press = 1'b1;
                  w_hold  = '0;
                  w_rcnt  = '0;
               end else begin
                  w_deb = r_deb + DW'(1);
               end
            end
         end

         HELD: begin
            if (!r_sync2) begin
               w_state = RELEASE_WAIT;
               w_ret   = HELD;
               w_deb   = '0;
            end else if (i_tick) begin
               if (r_hold == LONG_LAST) begin
                  w_state = REPEAT;
                  w_long  = 1'b1;
                  w_rcnt  = '0;
               end else begin
                  w_hold = r_hold + HW'(1);
               end
            end
         end

         REPEAT: begin
            if (!r_sync2) begin
               w_state = RELEASE_WAIT;
               w_ret   = REPEAT;
               w_deb   = '0;
            end else if (i_tick) begin
               if (r_rcnt == REP_LAST) begin
                  w_rep  = 1'b1;
                  w_rcnt = '0;
               end else begin
                  w_rcnt = r_rcnt + RW'(1);
               end
            end
         end

         RELEASE_WAIT: begin
            // hold/repeat counters are left untouched here so a short
            // dropout resumes timing exactly where it stopped.
            if (r_sync2) begin
               w_state = r_ret;
            end else if (i_tick) begin
               if (r_deb == DEB_LAST) begin
                  w_state = IDLE;
                  w_level = 1'b0;
                  w_rel   = 1'b1;
               end else begin
                  w_deb = r_deb + DW'(1);
               end
            end
         end

         default: begin
            w_state = IDLE;
            w_level = 1'b0;
         end
      endcase
   end

   assign o_level     = r_level;
   assign o_press     = r_press;
   assign o_press_nxt = w_press;
   assign o_release   = r_rel;
   assign o_long      = r_long;
   assign o_rep       = r_rep;

endmodule

// File: rtl/key_conditioner.sv
// Purpose : conditions N_KEYS washer pushbuttons into clean levels and event pulses.
// Latency : pin to sync 2 CLK; press/release accepted after DEB_MS-1..DEB_MS ms; outputs registered.
// Backpress: none; consumers must take every 1-CLK pulse as it occurs.
//
// Ports:
//   CLK  - system clock.
//   CLR  - asynchronous active-high reset.
//   keys - key_conditioner_if.master: key_raw in; key_level/press/release/long/rep/any out.
module key_conditioner
   import key_pkg::*;
#(
   parameter int N_KEYS      = 4,
   parameter int TICK_DIV    = 50000,
   parameter int DEB_MS      = 20,
   parameter int LONG_MS     = 1000,
   parameter int REP_MS      = 200,
   parameter bit ACTIVE_HIGH = 1'b1
) (
   input  logic                  CLK,
   input  logic                  CLR,
   key_conditioner_if.master     keys
);

   localparam int PW = cnt_width(TICK_DIV);
   localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

   // Shared 1 ms prescaler; every channel steps its counters on the same
   // tick so one divider serves all keys.
   logic [PW-1:0] r_pre;
   logic          w_tick;

   assign w_tick = (r_pre == TICK_LAST);

   always_ff @(posedge CLK or posedge CLR) begin
      if (CLR) begin
         r_pre <= '0;
      end else if (w_tick) begin
         r_pre <= '0;
      end else begin
         r_pre <= r_pre + PW'(1);
      end
   end

   logic [N_KEYS-1:0] w_level;
   logic [N_KEYS-1:0] w_press;
   logic [N_KEYS-1:0] w_press_nxt;
   logic [N_KEYS-1:0] w_rel;
   logic [N_KEYS-1:0] w_long;
   logic [N_KEYS-1:0] w_rep;

   for (genvar g = 0; g < N_KEYS; g++) begin : g_ch
      key_channel #(
         .DEB_MS      (DEB_MS),
         .LONG_MS     (LONG_MS),
         .REP_MS      (REP_MS),
         .ACTIVE_HIGH (ACTIVE_HIGH)
      ) u_ch (
         .CLK         (CLK),
         .CLR         (CLR),
         .i_raw       (keys.key_raw[g]),
         .i_tick      (w_tick),
         .o_level     (w_level[g]),
         .o_press     (w_press[g]),
         .o_press_nxt (w_press_nxt[g]),
         .o_release   (w_rel[g]),
         .o_long      (w_long[g]),
         .o_rep       (w_rep[g])
      );
   end

   // key_any is built from the channels' next-press values so it lands in
   // the same cycle as key_press; simultaneous presses merge into one pulse.
   logic r_any;

   always_ff @(posedge CLK or posedge CLR) begin
      if (CLR) begin
         r_any <= 1'b0;
      end else begin
         r_any <= |w_press_nxt;
      end
   end

   assign keys.key_level   = w_level;
   assign keys.key_press   = w_press;
   assign keys.key_release = w_rel;
   assign keys.key_long    = w_long;
   assign keys.key_rep     = w_rep;
   assign keys.key_any     = r_any;

endmodule

// File: tb/tb_key_conditioner.sv
module tb_key_conditioner;
   import key_pkg::*;

   localparam int NK = 4;
   localparam int TD = 10;
   localparam int DB = 3;
   localparam int LG = 8;
   localparam int RP = 4;

   logic CLK = 1'b0;
   logic CLR = 1'b1;

   key_conditioner_if #(.N_KEYS(NK)) kif ();

   key_conditioner #(
      .N_KEYS      (NK),
      .TICK_DIV    (TD),
      .DEB_MS      (DB),
      .LONG_MS     (LG),
      .REP_MS      (RP),
      .ACTIVE_HIGH (1'b1)
   ) dut (
      .CLK  (CLK),
      .CLR  (CLR),
      .keys (kif.master)
   );

   always #5 CLK = ~CLK;

   int errors = 0;
   int checks = 0;

   // Event monitor: samples 1 time unit after each rising edge.
   int cyc = 0;
   bit mon_clr = 1'b0;
   int press_cnt[NK], rel_cnt[NK], long_cnt[NK], rep_cnt[NK], lvl_cnt[NK];
   int press_t[NK], rel_t[NK], long_t[NK], rep_t0[NK], rep_t1[NK];
   int any_cnt, any_t;

   always @(posedge CLK) begin
      cyc = cyc + 1;
      #1;
      if (mon_clr) begin
         for (int k = 0; k < NK; k++) begin
            press_cnt[k] = 0; rel_cnt[k] = 0; long_cnt[k] = 0; rep_cnt[k] = 0; lvl_cnt[k] = 0;
            press_t[k] = 0; rel_t[k] = 0; long_t[k] = 0; rep_t0[k] = 0; rep_t1[k] = 0;
         end
         any_cnt = 0;
         any_t   = 0;
      end else begin
         for (int k = 0; k < NK; k++) begin
            if (kif.key_press[k])   begin press_cnt[k]++; press_t[k] = cyc; end
            if (kif.key_release[k]) begin rel_cnt[k]++;   rel_t[k]   = cyc; end
            if (kif.key_long[k])    begin long_cnt[k]++;  long_t[k]  = cyc; end
            if (kif.key_rep[k]) begin
               if (rep_cnt[k] == 0) rep_t0[k] = cyc;
               rep_t1[k] = cyc;
               rep_cnt[k]++;
            end
            if (kif.key_level[k]) lvl_cnt[k]++;
         end
         if (kif.key_any) begin any_cnt++; any_t = cyc; end
      end
   end

   task automatic mon_reset();
      mon_clr = 1'b1;
      @(negedge CLK);
      mon_clr = 1'b0;
   endtask

   // kind: 0 press, 1 release, 2 long, 3 repeat. Bounded wait.
   task automatic wait_evt(input int kind, input int k, input int maxc, output bit seen);
      int n;
      seen = 1'b0;
      for (int i = 0; i < maxc; i++) begin
         case (kind)
            0:       n = press_cnt[k];
            1:       n = rel_cnt[k];
            2:       n = long_cnt[k];
            default: n = rep_cnt[k];
         endcase
         if (n != 0) begin
            seen = 1'b1;
            break;
         end
         @(negedge CLK);
      end
   endtask

   task automatic test_reset();
      kif.key_raw = '0;
      CLR = 1'b1;
      repeat (3) @(negedge CLK);
      checks++;
      if (kif.key_level !== 4'b0000) begin errors++; $display("FAIL reset_level: got %b expected 0000", kif.key_level); end
      checks++;
      if ({kif.key_press, kif.key_release, kif.key_long, kif.key_rep} !== 16'h0000) begin
         errors++; $display("FAIL reset_pulses: got %h expected 0000", {kif.key_press, kif.key_release, kif.key_long, kif.key_rep});
      end
      checks++;
      if (kif.key_any !== 1'b0) begin errors++; $display("FAIL reset_any: got %b expected 0", kif.key_any); end
      CLR = 1'b0;
      mon_reset();
      repeat (40) @(negedge CLK);
      checks++;
      if (press_cnt[0] + press_cnt[1] + press_cnt[2] + press_cnt[3] + any_cnt != 0) begin
         errors++; $display("FAIL idle_no_press: got %0d expected 0", press_cnt[0] + press_cnt[1] + press_cnt[2] + press_cnt[3] + any_cnt);
      end
   endtask

   // Raw edge at cycle c: sync at c+2, PRESS_WAIT from c+3, third tick
   // lands at c+24..c+33 depending on prescaler phase.
   task automatic test_clean_press();
      int t0, t1, d;
      bit seen;
      mon_reset();
      t0 = cyc;
      kif.key_raw[K_SETM] = 1'b1;
      wait_evt(0, K_SETM, 60, seen);
      checks++;
      if (!seen) begin errors++; $display("FAIL press_k2_timeout: got none expected press"); end
      d = press_t[K_SETM] - t0;
      checks++;
      if (d < 24 || d > 33) begin errors++; $display("FAIL press_k2_delay: got %0d expected 24..33", d); end
      checks++;
      if (kif.key_level[K_SETM] !== 1'b1) begin errors++; $display("FAIL level_k2_high: got %b expected 1", kif.key_level[K_SETM]); end
      while (cyc < t0 + 50) @(negedge CLK);
      t1 = cyc;
      kif.key_raw[K_SETM] = 1'b0;
      wait_evt(1, K_SETM, 60, seen);
      checks++;
      if (!seen) begin errors++; $display("FAIL release_k2_timeout: got none expected release"); end
      d = rel_t[K_SETM] - t1;
      checks++;
      if (d < 24 || d > 33) begin errors++; $display("FAIL release_k2_delay: got %0d expected 24..33", d); end
      repeat (20) @(negedge CLK);
      checks++;
      if (kif.key_level[K_SETM] !== 1'b0) begin errors++; $display("FAIL level_k2_low: got %b expected 0", kif.key_level[K_SETM]); end
      checks++;
      if (press_cnt[K_SETM] !== 1 || rel_cnt[K_SETM] !== 1) begin
         errors++; $display("FAIL k2_counts: got press=%0d rel=%0d expected 1/1", press_cnt[K_SETM], rel_cnt[K_SETM]);
      end
      checks++;
      if (long_cnt[K_SETM] !== 0) begin errors++; $display("FAIL k2_no_long: got %0d expected 0", long_cnt[K_SETM]); end
      checks++;
      if (any_cnt !== 1 || any_t !== press_t[K_SETM]) begin
         errors++; $display("FAIL k2_any: got cnt=%0d t=%0d expected 1 at %0d", any_cnt, any_t, press_t[K_SETM]);
      end
   endtask

   task automatic test_chatter();
      mon_reset();
      for (int i = 0; i < 10; i++) begin
         kif.key_raw[K_POWER] = 1'b1;
         repeat (TD) @(negedge CLK);
         kif.key_raw[K_POWER] = 1'b0;
         repeat (TD) @(negedge CLK);
      end
      repeat (40) @(negedge CLK);
      checks++;
      if (press_cnt[K_POWER] + rel_cnt[K_POWER] + long_cnt[K_POWER] + rep_cnt[K_POWER] != 0) begin
         errors++; $display("FAIL chatter_pulses: got %0d expected 0", press_cnt[K_POWER] + rel_cnt[K_POWER] + long_cnt[K_POWER] + rep_cnt[K_POWER]);
      end
      checks++;
      if (lvl_cnt[K_POWER] !== 0) begin errors++; $display("FAIL chatter_level: got %0d cycles high expected 0", lvl_cnt[K_POWER]); end
      checks++;
      if (any_cnt !== 0) begin errors++; $display("FAIL chatter_any: got %0d expected 0", any_cnt); end
   endtask

   // Press at tick edge P; long at P+8 ticks = P+80, reps at +40 and +80 more.
   task automatic test_long_repeat();
      int t0, t1, d;
      bit seen;
      mon_reset();
      t0 = cyc;
      kif.key_raw[K_SETW] = 1'b1;
      wait_evt(0, K_SETW, 60, seen);
      d = press_t[K_SETW] - t0;
      checks++;
      if (!seen || d < 24 || d > 33) begin errors++; $display("FAIL press_k3_delay: got %0d expected 24..33", d); end
      while (cyc < t0 + 200) @(negedge CLK);
      t1 = cyc;
      kif.key_raw[K_SETW] = 1'b0;
      wait_evt(1, K_SETW, 60, seen);
      d = rel_t[K_SETW] - t1;
      checks++;
      if (!seen || d < 24 || d > 33) begin errors++; $display("FAIL release_k3_delay: got %0d expected 24..33", d); end
      repeat (20) @(negedge CLK);
      checks++;
      if (long_cnt[K_SETW] !== 1) begin errors++; $display("FAIL long_k3_count: got %0d expected 1", long_cnt[K_SETW]); end
      checks++;
      if (long_t[K_SETW] - press_t[K_SETW] !== 80) begin
         errors++; $display("FAIL long_k3_time: got %0d expected 80", long_t[K_SETW] - press_t[K_SETW]);
      end
      checks++;
      if (rep_cnt[K_SETW] !== 2) begin errors++; $display("FAIL rep_k3_count: got %0d expected 2", rep_cnt[K_SETW]); end
      checks++;
      if (rep_t0[K_SETW] - long_t[K_SETW] !== 40) begin
         errors++; $display("FAIL rep_k3_first: got %0d expected 40", rep_t0[K_SETW] - long_t[K_SETW]);
      end
      checks++;
      if (rep_t1[K_SETW] - rep_t0[K_SETW] !== 40) begin
         errors++; $display("FAIL rep_k3_period: got %0d expected 40", rep_t1[K_SETW] - rep_t0[K_SETW]);
      end
      checks++;
      if (rel_cnt[K_SETW] !== 1 || press_cnt[K_SETW] !== 1) begin
         errors++; $display("FAIL k3_counts: got press=%0d rel=%0d expected 1/1", press_cnt[K_SETW], rel_cnt[K_SETW]);
      end
   endtask

   // Dropout driven at P+42: RELEASE_WAIT spans edges P+45..P+55, so the
   // tick at P+50 is not counted and long moves from P+80 to P+90.
   task automatic test_glitch();
      bit seen;
      mon_reset();
      kif.key_raw[K_STOP] = 1'b1;
      wait_evt(0, K_STOP, 60, seen);
      checks++;
      if (!seen) begin errors++; $display("FAIL press_k1_timeout: got none expected press"); end
      while (cyc < press_t[K_STOP] + 42) @(negedge CLK);
      kif.key_raw[K_STOP] = 1'b0;
      repeat (TD) @(negedge CLK);
      kif.key_raw[K_STOP] = 1'b1;
      wait_evt(2, K_STOP, 150, seen);
      checks++;
      if (!seen || long_t[K_STOP] - press_t[K_STOP] !== 90) begin
         errors++; $display("FAIL long_k1_time: got %0d expected 90", long_t[K_STOP] - press_t[K_STOP]);
      end
      checks++;
      if (rel_cnt[K_STOP] !== 0 || press_cnt[K_STOP] !== 1) begin
         errors++; $display("FAIL glitch_k1_counts: got rel=%0d press=%0d expected 0/1", rel_cnt[K_STOP], press_cnt[K_STOP]);
      end
      checks++;
      if (lvl_cnt[K_STOP] !== long_t[K_STOP] - press_t[K_STOP] + 1) begin
         errors++; $display("FAIL glitch_k1_level: got %0d cycles expected %0d", lvl_cnt[K_STOP], long_t[K_STOP] - press_t[K_STOP] + 1);
      end
      kif.key_raw[K_STOP] = 1'b0;
      wait_evt(1, K_STOP, 60, seen);
      repeat (20) @(negedge CLK);
   endtask

   task automatic test_simultaneous();
      bit seen;
      mon_reset();
      kif.key_raw[1:0] = 2'b11;
      wait_evt(0, K_POWER, 60, seen);
      repeat (3) @(negedge CLK);
      checks++;
      if (!seen || press_cnt[K_POWER] !== 1 || press_cnt[K_STOP] !== 1) begin
         errors++; $display("FAIL simul_counts: got k0=%0d k1=%0d expected 1/1", press_cnt[K_POWER], press_cnt[K_STOP]);
      end
      checks++;
      if (press_t[K_POWER] !== press_t[K_STOP]) begin
         errors++; $display("FAIL simul_same_cycle: got %0d vs %0d expected equal", press_t[K_POWER], press_t[K_STOP]);
      end
      checks++;
      if (any_cnt !== 1 || any_t !== press_t[K_POWER]) begin
         errors++; $display("FAIL simul_any: got cnt=%0d t=%0d expected 1 at %0d", any_cnt, any_t, press_t[K_POWER]);
      end
      kif.key_raw[1:0] = 2'b00;
      wait_evt(1, K_STOP, 60, seen);
      repeat (20) @(negedge CLK);
   endtask

   // After CLR drops at cycle c the prescaler restarts from 0, so ticks
   // fall at c+10/20/30 and the re-press lands exactly at c+30.
   task automatic test_clr_mid();
      int t0;
      bit seen;
      mon_reset();
      kif.key_raw[K_SETW] = 1'b1;
      wait_evt(3, K_SETW, 200, seen);
      checks++;
      if (!seen) begin errors++; $display("FAIL clr_k3_no_repeat: got none expected repeat"); end
      repeat (3) @(negedge CLK);
      CLR = 1'b1;
      #1;
      checks++;
      if (kif.key_level !== 4'b0000 || kif.key_any !== 1'b0) begin
         errors++; $display("FAIL clr_async_level: got %b any=%b expected 0000 any=0", kif.key_level, kif.key_any);
      end
      checks++;
      if ({kif.key_press, kif.key_release, kif.key_long, kif.key_rep} !== 16'h0000) begin
         errors++; $display("FAIL clr_async_pulses: got %h expected 0000", {kif.key_press, kif.key_release, kif.key_long, kif.key_rep});
      end
      @(negedge CLK);
      mon_reset();
      repeat (2) @(negedge CLK);
      t0 = cyc;
      CLR = 1'b0;
      wait_evt(0, K_SETW, 60, seen);
      checks++;
      if (!seen || press_t[K_SETW] - t0 !== 30) begin
         errors++; $display("FAIL clr_repress_delay: got %0d expected 30", press_t[K_SETW] - t0);
      end
      checks++;
      if (rel_cnt[K_SETW] !== 0) begin errors++; $display("FAIL clr_no_release: got %0d expected 0", rel_cnt[K_SETW]); end
      kif.key_raw[K_SETW] = 1'b0;
      wait_evt(1, K_SETW, 60, seen);
      repeat (20) @(negedge CLK);
   endtask

   initial begin
      kif.key_raw = '0;
      @(negedge CLK);
      test_reset();
      test_clean_press();
      test_chatter();
      test_long_repeat();
      test_glitch();
      test_simultaneous();
      test_clr_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got no finish expected finish before 1000000");
      $fatal(1, "watchdog expired");
   end

endmodule
